ofm_stream_out: RTL

//  Downstream drain stage for the conv/maxpool core. After a layer completes, it reads the OFM DPRAM

---
 rtl/ofm_stream_pkg.sv | 15 +
 rtl/ofm_skid_fifo.sv | 51 +++++
 rtl/ofm_stream_out.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ofm_stream_pkg.sv
// Shared types and widths for the OFM drain stage: FSM encoding and counter widths.
package ofm_stream_pkg;

    localparam int WCNT_W = 25;  // word counter width (ceil(elems/16) fits)
    localparam int ELEM_W = 29;  // 9b * 9b * 11b element product

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        STREAM,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/ofm_skid_fifo.sv
// Two-entry skid FIFO between the RAM read port and the stream master.
// Head is zero while empty so the stream bus never shows stale data.
module ofm_skid_fifo #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the count gates visibility, so flushing it on reset is enough.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ofm_stream_out.sv
// Drains a finished layer from the OFM DPRAM port A onto a valid/ready stream,
// one RAM word per beat, with a two-word credit loop so the skid FIFO never overflows.
module ofm_stream_out
    import ofm_stream_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int INOUT_WIDTH   = 256,
    parameter int SYSTOLIC_SIZE = 16,
    parameter int OFM_RAM_SIZE  = 62500,
    parameter int AW            = $clog2(OFM_RAM_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8:0]             ofm_size,
    input  logic [10:0]            num_filter,
    input  logic [AW-1:0]          base_addr,
    output logic                   re_a,
    output logic [AW-1:0]          addr_a,
    input  logic [INOUT_WIDTH-1:0] dout_a,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [INOUT_WIDTH-1:0] m_data,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err_ovf
);

    localparam int WORD_W = DATA_WIDTH * SYSTOLIC_SIZE;
    localparam int SHIFT  = $clog2(SYSTOLIC_SIZE);

    state_t              state_q, state_d;
    logic [8:0]          ofm_size_q;
    logic [10:0]         num_filter_q;
    logic [AW-1:0]       base_q;
    logic [WCNT_W-1:0]   words_q;
    logic [WCNT_W-1:0]   rd_cnt_q;
    logic [WCNT_W-1:0]   beat_cnt_q;
    logic                inflight_q;
    logic                err_q;

    // Word-count arithmetic, evaluated while in CALC.
    logic [ELEM_W-1:0]   elems;
    logic [ELEM_W:0]     elems_rnd;
    logic [WCNT_W-1:0]   words_raw;
    logic [WCNT_W-1:0]   ram_words;
    logic [WCNT_W-1:0]   base_ext;
    logic [WCNT_W:0]     end_ext;
    logic                ovf;
    logic [WCNT_W-1:0]   avail;
    logic [WCNT_W-1:0]   words_calc;
    logic [WCNT_W-1:0]   last_idx;

    logic                fifo_full;
    logic                fifo_empty;
    logic [1:0]          fifo_count;
    logic                pop;
    logic [2:0]          held;
    logic                issue;

    assign elems     = ELEM_W'(ofm_size_q) * ELEM_W'(ofm_size_q) * ELEM_W'(num_filter_q);
    assign elems_rnd = {1'b0, elems} + (ELEM_W+1)'(SYSTOLIC_SIZE - 1);
    assign words_raw = WCNT_W'(elems_rnd >> SHIFT);
    assign ram_words = WCNT_W'(OFM_RAM_SIZE);
    assign base_ext  = WCNT_W'(base_q);
    assign end_ext   = {1'b0, words_raw} + {1'b0, base_ext};
    assign ovf       = end_ext > {1'b0, ram_words};
    // Clamp to the words left above base so the AW-bit address never wraps.
    assign avail      = (base_ext >= ram_words) ? '0 : (ram_words - base_ext);
    assign words_calc = ovf ? avail : words_raw;
    assign last_idx   = words_q - WCNT_W'(1);

    // Credit: words in flight plus words stored, less the one leaving this clk, must stay below 2.
    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;
    assign held    = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue   = (state_q == STREAM) && (held < 3'd2);

    assign re_a    = issue;
    assign addr_a  = issue ? (base_q + rd_cnt_q[AW-1:0]) : '0;
    assign m_last  = m_valid && (beat_cnt_q == last_idx);
    assign busy    = (state_q == CALC) || (state_q == STREAM) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    assign err_ovf = err_q;

    always_comb begin
        // NOTE: next state defaults to the current one first, so no path leaves it unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start) state_d = CALC;
            CALC:   state_d = (words_calc == '0) ? DONE : STREAM;
            STREAM: if (issue && (rd_cnt_q == last_idx)) state_d = DRAIN;
            DRAIN:  if (pop && (beat_cnt_q == last_idx)) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ofm_size_q   <= '0;
            num_filter_q <= '0;
            base_q       <= '0;
            words_q      <= '0;
            rd_cnt_q     <= '0;
            beat_cnt_q   <= '0;
            inflight_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if ((state_q == IDLE) && start) begin
                ofm_size_q   <= ofm_size;
                num_filter_q <= num_filter;
                base_q       <= base_addr;
                words_q      <= '0;
                rd_cnt_q     <= '0;
                beat_cnt_q   <= '0;
                err_q        <= 1'b0;
            end
            if (state_q == CALC) begin
                words_q <= words_calc;
                if (ovf) err_q <= 1'b1;
            end
            if (issue) rd_cnt_q   <= rd_cnt_q + WCNT_W'(1);
            if (pop)   beat_cnt_q <= beat_cnt_q + WCNT_W'(1);
        end
    end

    ofm_skid_fifo #(
        .WIDTH(WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (dout_a),
        .pop       (pop),
        .head      (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A read landing on a full FIFO would be lost; the credit rule must make this impossible.
    credit_bound: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_full && inflight_q));

endmodule
